// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial front end feeding the sequence detector.
// Words arrive over valid/ready and leave one bit per clock on serial_out. A
// one-word hold register lets consecutive words stream without an idle gap.
module bit_serializer #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CNT_W    = 16,
  parameter logic        IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  input  logic             lsb_first,
  output logic             word_ready,
  output logic             serial_out,
  output logic             bit_valid,
  output logic             busy,
  output logic [CNT_W-1:0] words_sent
);

  localparam int unsigned BCNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(WIDTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic               dir_q, dir_d;
  logic [BCNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]   hold_q, hold_d;
  logic               hold_dir_q, hold_dir_d;
  logic               hold_full_q, hold_full_d;
  logic               ready_q, ready_d;
  logic               serial_q, serial_d;
  logic               bit_valid_q, bit_valid_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   words_q, words_d;

  logic               accept_c;
  logic               last_c;
  logic               load_en;
  logic [WIDTH-1:0]   load_w;
  logic               load_dir;

  // First bit of a word in the requested order.
  function automatic logic first_bit(input logic [WIDTH-1:0] w, input logic lsb);
    return lsb ? w[0] : w[WIDTH-1];
  endfunction

  // Drop the bit just emitted so the next one sits at the emitting end.
  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] w, input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  assign accept_c = word_valid && ready_q;
  assign last_c   = (bit_cnt_q == LAST_BIT);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: leave SHIFT only when the final bit ends with nothing queued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept_c) state_d = ST_SHIFT;
      ST_SHIFT: if (last_c && !hold_full_q && !accept_c) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: shifting, hold capture, reload on the final bit, counting.
  always_comb begin
    shift_d     = shift_q;
    dir_d       = dir_q;
    bit_cnt_d   = bit_cnt_q;
    hold_d      = hold_q;
    hold_dir_d  = hold_dir_q;
    hold_full_d = hold_full_q;
    serial_d    = serial_q;
    bit_valid_d = bit_valid_q;
    words_d     = words_q;
    load_en     = 1'b0;
    load_w      = word_in;
    load_dir    = lsb_first;

    case (state_q)
      ST_IDLE: begin
        serial_d    = IDLE_BIT;
        bit_valid_d = 1'b0;
        bit_cnt_d   = '0;
        load_en     = accept_c;
      end
      ST_SHIFT: begin
        if (last_c) begin
          words_d = words_q + CNT_W'(1);
          if (hold_full_q) begin
            load_en     = 1'b1;
            load_w      = hold_q;
            load_dir    = hold_dir_q;
            hold_full_d = 1'b0;
          end else if (accept_c) begin
            load_en = 1'b1;
          end else begin
            serial_d    = IDLE_BIT;
            bit_valid_d = 1'b0;
            bit_cnt_d   = '0;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BCNT_W'(1);
          serial_d  = first_bit(shift_q, dir_q);
          shift_d   = shift_once(shift_q, dir_q);
          if (accept_c && !hold_full_q) begin
            hold_d      = word_in;
            hold_dir_d  = lsb_first;
            hold_full_d = 1'b1;
          end
        end
      end
      default: begin
        serial_d    = IDLE_BIT;
        bit_valid_d = 1'b0;
      end
    endcase

    // A load puts the first bit on the line at the very next edge.
    if (load_en) begin
      shift_d     = shift_once(load_w, load_dir);
      dir_d       = load_dir;
      serial_d    = first_bit(load_w, load_dir);
      bit_valid_d = 1'b1;
      bit_cnt_d   = '0;
    end

    ready_d = !hold_full_d;
    busy_d  = (state_d == ST_SHIFT) || hold_full_d;
  end

  // Datapath and output registers; reset clears everything including the hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q     <= '0;
      dir_q       <= 1'b0;
      bit_cnt_q   <= '0;
      hold_q      <= '0;
      hold_dir_q  <= 1'b0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b0;
      serial_q    <= IDLE_BIT;
      bit_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      words_q     <= '0;
    end else begin
      shift_q     <= shift_d;
      dir_q       <= dir_d;
      bit_cnt_q   <= bit_cnt_d;
      hold_q      <= hold_d;
      hold_dir_q  <= hold_dir_d;
      hold_full_q <= hold_full_d;
      ready_q     <= ready_d;
      serial_q    <= serial_d;
      bit_valid_q <= bit_valid_d;
      busy_q      <= busy_d;
      words_q     <= words_d;
    end
  end

  assign word_ready = ready_q;
  assign serial_out = serial_q;
  assign bit_valid  = bit_valid_q;
  assign busy       = busy_q;
  assign words_sent = words_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Testbench for bit_serializer: scoreboard of expected serial bits, directed steps.
module tb_bit_serializer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [7:0]  word_in = 8'h00;
  logic        word_valid = 1'b0;
  logic        lsb_first = 1'b0;

  logic        word_ready, serial_out, bit_valid, busy;
  logic [15:0] words_sent;
  logic        word_ready_b, serial_out_b, bit_valid_b, busy_b;
  logic [1:0]  words_sent_b;

  int   checks = 0;
  int   failures = 0;
  logic exp_q[$];
  bit   mon_en = 1'b0;
  int   run_len = 0;
  int   last_run = 0;
  int   exp2[5] = '{1, 2, 3, 0, 1};

  bit_serializer dut (
    .clk(clk), .reset_n(reset_n), .word_in(word_in), .word_valid(word_valid),
    .lsb_first(lsb_first), .word_ready(word_ready), .serial_out(serial_out),
    .bit_valid(bit_valid), .busy(busy), .words_sent(words_sent)
  );

  bit_serializer #(.CNT_W(2)) dut_w2 (
    .clk(clk), .reset_n(reset_n), .word_in(word_in), .word_valid(word_valid),
    .lsb_first(lsb_first), .word_ready(word_ready_b), .serial_out(serial_out_b),
    .bit_valid(bit_valid_b), .busy(busy_b), .words_sent(words_sent_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bit monitor: every valid bit is popped from the scoreboard; idle line must be IDLE_BIT.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bit_valid === 1'b1) begin
        run_len++;
        if (exp_q.size() == 0) begin
          check("bit_expected", 32'(exp_q.size()), 32'd1);
        end else begin
          check("serial_bit", 32'(serial_out), 32'(exp_q.pop_front()));
        end
      end else begin
        if (run_len != 0) last_run = run_len;
        run_len = 0;
        check("idle_line", 32'(serial_out), 32'd0);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    word_valid = 1'b0;
    #1;
    check("rst_serial", 32'(serial_out), 32'd0);
    check("rst_bit_valid", 32'(bit_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(word_ready), 32'd0);
    check("rst_words", 32'(words_sent), 32'd0);
    check("rst_words_w2", 32'(words_sent_b), 32'd0);
    exp_q.delete();
    run_len = 0;
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_release", 32'(word_ready), 32'd1);
    check("busy_after_release", 32'(busy), 32'd0);
  endtask

  // Present a word and wait until it is accepted; returns #1 after the accept edge.
  task automatic send(input logic [7:0] w, input logic lsb);
    bit done = 1'b0;
    word_in = w;
    lsb_first = lsb;
    word_valid = 1'b1;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (word_ready === 1'b1) begin
        for (int i = 0; i < 8; i++) exp_q.push_back(lsb ? w[i] : w[7-i]);
        done = 1'b1;
      end
    end
    check("send_accept", 32'(done), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge clk);
      if (busy === 1'b0 && bit_valid === 1'b0) ok = 1'b1;
    end
    check("idle_reached", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    mon_en = 1'b1;

    // 1: single MSB-first word
    send(8'h99, 1'b0);
    word_valid = 1'b0;
    check("t1_busy", 32'(busy), 32'd1);
    wait_idle();
    check("t1_run", 32'(last_run), 32'd8);
    check("t1_words", 32'(words_sent), 32'd1);

    // 2: back-to-back with valid held; second word goes to hold
    send(8'h90, 1'b0);
    send(8'h0F, 1'b0);
    word_valid = 1'b0;
    check("t2_ready_low", 32'(word_ready), 32'd0);
    check("t2_busy", 32'(busy), 32'd1);
    wait_idle();
    check("t2_run", 32'(last_run), 32'd16);
    check("t2_words", 32'(words_sent), 32'd3);
    check("t2_ready_back", 32'(word_ready), 32'd1);

    // 3: bit order selection per word
    send(8'h01, 1'b1);
    send(8'h01, 1'b0);
    word_valid = 1'b0;
    wait_idle();
    check("t3_run", 32'(last_run), 32'd16);
    check("t3_words", 32'(words_sent), 32'd5);

    // 4: async reset mid-word with a word held
    send(8'hFF, 1'b0);
    send(8'h3C, 1'b1);
    word_valid = 1'b0;
    @(posedge clk);
    #1;
    check("t4_ready_held", 32'(word_ready), 32'd0);
    do_reset();
    send(8'hA5, 1'b0);
    word_valid = 1'b0;
    check("t4_words_before", 32'(words_sent), 32'd0);
    wait_idle();
    check("t4_run", 32'(last_run), 32'd8);
    check("t4_words_after", 32'(words_sent), 32'd1);

    // 5: accept exactly on the final-bit edge with hold empty
    send(8'hC3, 1'b0);
    word_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    send(8'h5A, 1'b1);
    word_valid = 1'b0;
    @(negedge clk);
    check("t5_bit_valid", 32'(bit_valid), 32'd1);
    check("t5_hold_empty", 32'(word_ready), 32'd1);
    wait_idle();
    check("t5_run", 32'(last_run), 32'd16);
    check("t5_words", 32'(words_sent), 32'd3);

    // 6: counter wrap on the 2-bit instance
    do_reset();
    for (int k = 0; k < 5; k++) begin
      send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      word_valid = 1'b0;
      wait_idle();
      check("t6_words", 32'(words_sent), 32'(k + 1));
      check("t6_words_w2", 32'(words_sent_b), 32'(exp2[k]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
